calc_engine: RTL and testbench

Parametrised keypad-driven integer calculator core. It accepts one hex key code per handshake and accumulates decimal operands. It evaluates add, subtract, multiply and an iterative divide left to right, and keeps a ring of past results that can be recalled. It sits between the keypad scanner and the display driver, replacing the fixed 32-bit calculator state machine.

---
 rtl/calc_pkg.sv | 48 ++++
 rtl/calc_if.sv | 38 +++
 rtl/calc_divider.sv | 86 ++++++++
 rtl/calc_engine.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_calc_engine.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_pkg                                                     |
// | Description : Shared definitions for the keypad calculator core: key code  |
// |               constants, operator and state encodings, key decode helpers. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package calc_pkg;

  localparam logic [3:0] KEY_ADD    = 4'hA;
  localparam logic [3:0] KEY_SUB    = 4'hB;
  localparam logic [3:0] KEY_MUL    = 4'hC;
  localparam logic [3:0] KEY_EQ     = 4'hD;
  localparam logic [3:0] KEY_RECALL = 4'hE;
  localparam logic [3:0] KEY_DIV    = 4'hF;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_ENTRY_A = 3'd0,
    ST_OP_PEND = 3'd1,
    ST_ENTRY_B = 3'd2,
    ST_DIVIDE  = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic op_e key_to_op(input logic [3:0] k);
    op_e r;
    case (k)
      KEY_SUB: r = OP_SUB;
      KEY_MUL: r = OP_MUL;
      KEY_DIV: r = OP_DIV;
      default: r = OP_ADD;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calc_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_if                                                      |
// | Description : Keypad/display bundle of the calculator core.                |
// |   key, key_valid      : keypad -> core, key code and valid                 |
// |   key_ready           : core -> keypad, key accepted when valid & ready    |
// |   display             : value to show                                      |
// |   overflow/error/busy : status flags                                       |
// |   hist_count          : number of valid history entries                    |
// | Modports    : master (keypad/display side), slave (calculator core)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface calc_if #(
  parameter int WIDTH       = 32,
  parameter int STACK_DEPTH = 16
) ();

  logic [3:0]                       key;
  logic                             key_valid;
  logic                             key_ready;
  logic [WIDTH-1:0]                 display;
  logic                             overflow;
  logic                             error;
  logic                             busy;
  logic [$clog2(STACK_DEPTH+1)-1:0] hist_count;

  modport master (
    output key, key_valid,
    input  key_ready, display, overflow, error, busy, hist_count
  );

  modport slave (
    input  key, key_valid,
    output key_ready, display, overflow, error, busy, hist_count
  );

endinterface
`default_nettype wire

// File: rtl/calc_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_divider                                                 |
// | Description : Unsigned restoring divider, one quotient bit per cycle.      |
// |   clock, reset       : clock, asynchronous active-low reset                |
// |   start              : load operands (ignored while busy)                  |
// |   dividend, divisor  : operands, sampled on start                          |
// |   busy               : high for exactly WIDTH cycles after start           |
// |   done               : high in the final iteration cycle                   |
// |   quotient           : final quotient, valid while done is high            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module calc_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  logic               r_busy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_div;
  logic [WIDTH-1:0]   r_quot;

  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_nxt;

  // The partial remainder stays below the divisor, so the shifted value is
  // below twice the divisor and the top bit of the difference is a clean
  // "went negative" flag.
  assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff     = w_shift - {1'b0, r_div};
  assign w_ge       = ~w_diff[WIDTH];
  assign w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], w_ge};

  assign busy     = r_busy;
  assign done     = r_busy && (r_cnt == c_last);
  // Exposing the next quotient lets the caller capture it on the same edge
  // that busy falls.
  assign quotient = w_quot_nxt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_dvd  <= '0;
      r_div  <= '0;
      r_quot <= '0;
    end else if (!r_busy) begin
      if (start) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_rem  <= '0;
        r_dvd  <= dividend;
        r_div  <= divisor;
        r_quot <= '0;
      end
    end else begin
      r_rem  <= w_rem_nxt;
      r_dvd  <= {r_dvd[WIDTH-2:0], 1'b0};
      r_quot <= w_quot_nxt;
      r_cnt  <= r_cnt + c_cnt_w'(1);
      if (r_cnt == c_last) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/calc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_engine                                                  |
// | Description : Keypad-driven integer calculator core. Accumulates decimal   |
// |               operands, evaluates + - * (and / when enabled) left to      |
// |               right, and keeps a recallable ring of past results.          |
// |   clock      : rising-edge clock                                           |
// |   reset      : asynchronous active-low reset                               |
// |   bus        : calc_if.slave (key/key_valid/key_ready, display, overflow,  |
// |                error, busy, hist_count)                                    |
// | Config      : CALC_DIV_EN - when defined, F is divide and the iterative    |
// |               divider, busy and error are present; otherwise F is ignored, |
// |               busy/error read 0 and key_ready is always 1.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module calc_engine
  import calc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DIGITS      = 9,
  parameter int STACK_DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  calc_if.slave bus
);

  localparam int c_cnt_w  = $clog2(STACK_DEPTH + 1);
  localparam int c_ptr_w  = $clog2(STACK_DEPTH);
  localparam int c_dcnt_w = $clog2(DIGITS + 1);
  localparam logic [c_dcnt_w-1:0] c_digits = c_dcnt_w'(DIGITS);
  localparam logic [c_cnt_w-1:0]  c_full   = c_cnt_w'(STACK_DEPTH);
  localparam logic [WIDTH+3:0]    c_ten    = (WIDTH+4)'(10);

  // Registered state
  state_e              r_state;
  logic [WIDTH-1:0]    r_acc_a;
  logic [WIDTH-1:0]    r_acc_b;
  op_e                 r_op;
  logic [c_dcnt_w-1:0] r_digit_cnt;
  logic [c_cnt_w-1:0]  r_recall_ptr;   // offset from newest of the next recall
  logic                r_recall_seq;   // previous accepted key was a recall
  logic                r_fresh;        // next digit starts a new entry
  logic                r_overflow;
  logic                r_error;
  logic                r_div_eq;       // divide was launched by '='
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_hist_count;
  logic [WIDTH-1:0]    r_hist [STACK_DEPTH];

  // Next-state values
  state_e              n_state;
  logic [WIDTH-1:0]    n_acc_a;
  logic [WIDTH-1:0]    n_acc_b;
  op_e                 n_op;
  logic [c_dcnt_w-1:0] n_digit_cnt;
  logic [c_cnt_w-1:0]  n_recall_ptr;
  logic                n_recall_seq;
  logic                n_fresh;
  logic                n_overflow;
  logic                n_error;
  logic                n_div_eq;
  logic [c_ptr_w-1:0]  n_wr_ptr;
  logic [c_cnt_w-1:0]  n_hist_count;

  // Combinational helpers
  logic                w_key_ready;
  logic                w_accept;
  logic                w_is_op;
  logic                w_is_eq;
  logic [WIDTH-1:0]    w_entry;
  logic [WIDTH+3:0]    w_app_wide;
  logic                w_digit_room;
  logic [WIDTH-1:0]    w_digit_val;
  logic [WIDTH:0]      w_sum;
  logic [WIDTH:0]      w_dif;
  logic [2*WIDTH-1:0]  w_prod;
  logic [WIDTH-1:0]    w_alu_res;
  logic                w_alu_ovf;
  logic [c_cnt_w-1:0]  w_rec_off;
  logic [c_cnt_w-1:0]  w_rec_next;
  logic [c_ptr_w-1:0]  w_rec_idx;
  logic                w_push;
  logic [WIDTH-1:0]    w_push_val;
  logic [WIDTH-1:0]    w_display;
  logic                w_div_busy;
  logic                w_div_done;
  logic [WIDTH-1:0]    w_div_q;

`ifdef CALC_DIV_EN
  logic                w_div_start;

  calc_divider #(.WIDTH(WIDTH)) u_divider (
    .clock    (clock),
    .reset    (reset),
    .start    (w_div_start),
    .dividend (r_acc_a),
    .divisor  (r_acc_b),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_div_q)
  );

  // DIVIDE is occupied exactly while the divider runs.
  assign w_key_ready = (r_state != ST_DIVIDE);
  assign w_is_op     = (bus.key == KEY_ADD) || (bus.key == KEY_SUB) ||
                       (bus.key == KEY_MUL) || (bus.key == KEY_DIV);
`else
  assign w_div_busy  = 1'b0;
  assign w_div_done  = 1'b0;
  assign w_div_q     = '0;
  assign w_key_ready = 1'b1;
  assign w_is_op     = (bus.key == KEY_ADD) || (bus.key == KEY_SUB) ||
                       (bus.key == KEY_MUL);
`endif

  assign w_accept = bus.key_valid & w_key_ready;
  assign w_is_eq  = (bus.key == KEY_EQ);

  // Digit append, computed four bits wider so "exceeds 2^WIDTH-1" is visible.
  assign w_entry      = (r_state == ST_ENTRY_B) ? r_acc_b : r_acc_a;
  assign w_app_wide   = ({4'b0000, w_entry} * c_ten) + {{WIDTH{1'b0}}, bus.key};
  assign w_digit_room = (r_digit_cnt < c_digits) && (w_app_wide[WIDTH+3:WIDTH] == 4'd0);
  assign w_digit_val  = r_fresh ? {{(WIDTH-4){1'b0}}, bus.key} : w_app_wide[WIDTH-1:0];

  assign w_sum  = {1'b0, r_acc_a} + {1'b0, r_acc_b};
  assign w_dif  = {1'b0, r_acc_a} - {1'b0, r_acc_b};
  assign w_prod = {{WIDTH{1'b0}}, r_acc_a} * {{WIDTH{1'b0}}, r_acc_b};

  always_comb begin
    w_alu_res = w_sum[WIDTH-1:0];
    w_alu_ovf = w_sum[WIDTH];
    case (r_op)
      OP_SUB: begin
        w_alu_res = w_dif[WIDTH-1:0];
        w_alu_ovf = w_dif[WIDTH];
      end
      OP_MUL: begin
        w_alu_res = w_prod[WIDTH-1:0];
        w_alu_ovf = |w_prod[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  // Recall walks backwards from the newest entry and wraps after hist_count.
  assign w_rec_off  = r_recall_seq ? r_recall_ptr : '0;
  assign w_rec_next = ((w_rec_off + c_cnt_w'(1)) == r_hist_count) ? '0
                                                                  : (w_rec_off + c_cnt_w'(1));
  assign w_rec_idx  = r_wr_ptr - c_ptr_w'(1) - w_rec_off[c_ptr_w-1:0];

  always_comb begin
    n_state      = r_state;
    n_acc_a      = r_acc_a;
    n_acc_b      = r_acc_b;
    n_op         = r_op;
    n_digit_cnt  = r_digit_cnt;
    n_recall_ptr = r_recall_ptr;
    n_recall_seq = r_recall_seq;
    n_fresh      = r_fresh;
    n_overflow   = r_overflow;
    n_error      = r_error;
    n_div_eq     = r_div_eq;
    n_wr_ptr     = r_wr_ptr;
    n_hist_count = r_hist_count;
    w_push       = 1'b0;
    w_push_val   = r_acc_a;
`ifdef CALC_DIV_EN
    w_div_start  = 1'b0;
`endif

    if (w_accept) begin
      n_recall_seq = 1'b0;
    end

    case (r_state)
      ST_ENTRY_A, ST_ENTRY_B: begin
        if (w_accept) begin
          if (is_digit(bus.key)) begin
            if (r_fresh || w_digit_room) begin
              if (r_state == ST_ENTRY_A) n_acc_a = w_digit_val;
              else                       n_acc_b = w_digit_val;
              n_digit_cnt = r_fresh ? c_dcnt_w'(1) : (r_digit_cnt + c_dcnt_w'(1));
              n_fresh     = 1'b0;
            end
          end else if (w_is_op || w_is_eq) begin
            if (r_state == ST_ENTRY_A) begin
              if (w_is_op) begin
                n_op    = key_to_op(bus.key);
                n_state = ST_OP_PEND;
              end else begin
                w_push  = 1'b1;
                n_fresh = 1'b1;
              end
            end else begin
`ifdef CALC_DIV_EN
              if (r_op == OP_DIV) begin
                n_overflow = 1'b0;
                if (r_acc_b == '0) begin
                  n_state = ST_ERROR;
                  n_error = 1'b1;
                end else begin
                  w_div_start = 1'b1;
                  n_state     = ST_DIVIDE;
                  n_div_eq    = w_is_eq;
                end
              end else
`endif
              begin
                n_acc_a    = w_alu_res;
                n_overflow = w_alu_ovf;
                if (w_is_eq) begin
                  w_push     = 1'b1;
                  w_push_val = w_alu_res;
                  n_state    = ST_ENTRY_A;
                  n_fresh    = 1'b1;
                end else begin
                  n_state = ST_OP_PEND;
                end
              end
              if (w_is_op) begin
                n_op = key_to_op(bus.key);
              end
            end
          end else if ((bus.key == KEY_RECALL) && (r_hist_count != '0)) begin
            if (r_state == ST_ENTRY_A) n_acc_a = r_hist[w_rec_idx];
            else                       n_acc_b = r_hist[w_rec_idx];
            n_recall_seq = 1'b1;
            n_recall_ptr = w_rec_next;
            n_fresh      = 1'b1;
          end
        end
      end

      ST_OP_PEND: begin
        if (w_accept) begin
          if (is_digit(bus.key)) begin
            n_acc_b     = {{(WIDTH-4){1'b0}}, bus.key};
            n_digit_cnt = c_dcnt_w'(1);
            n_fresh     = 1'b0;
            n_state     = ST_ENTRY_B;
          end else if (w_is_op) begin
            n_op = key_to_op(bus.key);
          end
        end
      end

      ST_DIVIDE: begin
        if (w_div_done) begin
          n_acc_a = w_div_q;
          if (r_div_eq) begin
            w_push     = 1'b1;
            w_push_val = w_div_q;
            n_state    = ST_ENTRY_A;
            n_fresh    = 1'b1;
          end else begin
            n_state = ST_OP_PEND;
          end
        end
      end

      ST_ERROR: begin
        if (w_accept && w_is_eq) begin
          n_state     = ST_ENTRY_A;
          n_error     = 1'b0;
          n_acc_a     = '0;
          n_acc_b     = '0;
          n_digit_cnt = '0;
          n_fresh     = 1'b1;
        end
      end

      default: n_state = ST_ENTRY_A;
    endcase

    // The pointer wraps naturally because STACK_DEPTH is a power of two.
    if (w_push) begin
      n_wr_ptr     = r_wr_ptr + c_ptr_w'(1);
      n_hist_count = (r_hist_count == c_full) ? r_hist_count
                                              : (r_hist_count + c_cnt_w'(1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_ENTRY_A;
      r_acc_a      <= '0;
      r_acc_b      <= '0;
      r_op         <= OP_ADD;
      r_digit_cnt  <= '0;
      r_recall_ptr <= '0;
      r_recall_seq <= 1'b0;
      r_fresh      <= 1'b1;
      r_overflow   <= 1'b0;
      r_error      <= 1'b0;
      r_div_eq     <= 1'b0;
      r_wr_ptr     <= '0;
      r_hist_count <= '0;
    end else begin
      r_state      <= n_state;
      r_acc_a      <= n_acc_a;
      r_acc_b      <= n_acc_b;
      r_op         <= n_op;
      r_digit_cnt  <= n_digit_cnt;
      r_recall_ptr <= n_recall_ptr;
      r_recall_seq <= n_recall_seq;
      r_fresh      <= n_fresh;
      r_overflow   <= n_overflow;
      r_error      <= n_error;
      r_div_eq     <= n_div_eq;
      r_wr_ptr     <= n_wr_ptr;
      r_hist_count <= n_hist_count;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        r_hist[i] <= '0;
      end
    end else if (w_push) begin
      r_hist[r_wr_ptr] <= w_push_val;
    end
  end

  always_comb begin
    w_display = r_acc_a;
    case (r_state)
      ST_ENTRY_B: w_display = r_acc_b;
      ST_ERROR:   w_display = '1;
      default:    w_display = r_acc_a;
    endcase
  end

  assign bus.key_ready  = w_key_ready;
  assign bus.display    = w_display;
  assign bus.overflow   = r_overflow;
  assign bus.error      = r_error;
  assign bus.busy       = w_div_busy;
  assign bus.hist_count = r_hist_count;

endmodule
`default_nettype wire

// File: tb/tb_calc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_calc_engine                                               |
// | Description : Directed self-checking bench for calc_engine (WIDTH 32,      |
// |               DIGITS 9, STACK_DEPTH 16). Divide scenarios are built when   |
// |               CALC_DIV_EN is defined; otherwise F is checked as ignored.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_calc_engine;
  import calc_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_pass;

  calc_if #(.WIDTH(32), .STACK_DEPTH(16)) bus ();

  calc_engine #(.WIDTH(32), .DIGITS(9), .STACK_DEPTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    bus.key_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  // Drive one key for one cycle; returns at the negedge after the accepting edge.
  task automatic press(input logic [3:0] k);
    @(negedge clock);
    bus.key       = k;
    bus.key_valid = 1'b1;
    @(negedge clock);
    bus.key_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.display !== 32'd0) $display("FAIL reset_display: got %0d expected 0", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", bus.overflow);
    else n_pass++;
    n_checks++;
    if (bus.error !== 1'b0) $display("FAIL reset_error: got %b expected 0", bus.error);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.key_ready !== 1'b1) $display("FAIL reset_key_ready: got %b expected 1", bus.key_ready);
    else n_pass++;
    n_checks++;
    if (bus.hist_count !== 5'd0) $display("FAIL reset_hist_count: got %0d expected 0", bus.hist_count);
    else n_pass++;
  endtask

  task automatic test_add();
    press(4'd1); press(4'd2);
    n_checks++;
    if (bus.display !== 32'd12) $display("FAIL add_entry_a: got %0d expected 12", bus.display);
    else n_pass++;
    press(KEY_ADD); press(4'd3); press(4'd4); press(KEY_EQ);
    n_checks++;
    if (bus.display !== 32'd46) $display("FAIL add_result: got %0d expected 46", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.hist_count !== 5'd1) $display("FAIL add_hist_count: got %0d expected 1", bus.hist_count);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL add_overflow: got %b expected 0", bus.overflow);
    else n_pass++;
  endtask

  task automatic test_sub_chain();
    press(4'd5); press(KEY_SUB); press(4'd7); press(KEY_EQ);
    n_checks++;
    if (bus.display !== 32'hFFFF_FFFE) $display("FAIL sub_wrap: got %0h expected fffffffe", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL sub_borrow: got %b expected 1", bus.overflow);
    else n_pass++;
    press(4'd3); press(KEY_MUL); press(4'd4); press(KEY_ADD);
    n_checks++;
    if (bus.display !== 32'd12) $display("FAIL chain_partial: got %0d expected 12", bus.display);
    else n_pass++;
    press(4'd2); press(KEY_EQ);
    n_checks++;
    if (bus.display !== 32'd14) $display("FAIL chain_result: got %0d expected 14", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b0) $display("FAIL chain_overflow: got %b expected 0", bus.overflow);
    else n_pass++;
  endtask

  // 99999 * 99999 = 9999800001 = 2*2^32 + 1409865409
  task automatic test_mul_wrap();
    repeat (5) press(4'd9);
    press(KEY_MUL);
    repeat (5) press(4'd9);
    press(KEY_EQ);
    n_checks++;
    if (bus.display !== 32'd1409865409) $display("FAIL mul_wrap: got %0d expected 1409865409", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.overflow !== 1'b1) $display("FAIL mul_overflow: got %b expected 1", bus.overflow);
    else n_pass++;
  endtask

  task automatic test_digits();
    do_reset();
    for (int i = 1; i <= 10; i++) press(4'(i % 10));
    n_checks++;
    if (bus.display !== 32'd123456789) $display("FAIL digit_limit: got %0d expected 123456789", bus.display);
    else n_pass++;
  endtask

  task automatic test_recall();
    do_reset();
    press(4'd7); press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd7) $display("FAIL recall_empty: got %0d expected 7", bus.display);
    else n_pass++;
    do_reset();
    press(4'd1); press(KEY_EQ); press(4'd2); press(KEY_EQ); press(4'd3); press(KEY_EQ);
    n_checks++;
    if (bus.hist_count !== 5'd3) $display("FAIL recall_hist_count: got %0d expected 3", bus.hist_count);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd3) $display("FAIL recall_1: got %0d expected 3", bus.display);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd2) $display("FAIL recall_2: got %0d expected 2", bus.display);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd1) $display("FAIL recall_3: got %0d expected 1", bus.display);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd3) $display("FAIL recall_wrap: got %0d expected 3", bus.display);
    else n_pass++;
    press(4'd4);
    n_checks++;
    if (bus.display !== 32'd4) $display("FAIL recall_fresh_digit: got %0d expected 4", bus.display);
    else n_pass++;
  endtask

  // 17 pushes into a 16-entry ring: values 0..9,0..6; the first (0) is lost.
  task automatic test_ring_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      press(4'(i % 10));
      press(KEY_EQ);
    end
    n_checks++;
    if (bus.hist_count !== 5'd16) $display("FAIL ring_saturate: got %0d expected 16", bus.hist_count);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd6) $display("FAIL ring_newest: got %0d expected 6", bus.display);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd5) $display("FAIL ring_second: got %0d expected 5", bus.display);
    else n_pass++;
    repeat (14) press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd1) $display("FAIL ring_oldest: got %0d expected 1", bus.display);
    else n_pass++;
    press(KEY_RECALL);
    n_checks++;
    if (bus.display !== 32'd6) $display("FAIL ring_rewrap: got %0d expected 6", bus.display);
    else n_pass++;
  endtask

`ifdef CALC_DIV_EN
  task automatic test_divide();
    int   n;
    logic kr_low;
    do_reset();
    press(4'd1); press(4'd0); press(4'd0); press(KEY_DIV); press(4'd7); press(KEY_EQ);
    n_checks++;
    if (bus.busy !== 1'b1) $display("FAIL div_busy_rise: got %b expected 1", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.display !== 32'd100) $display("FAIL div_display_acc: got %0d expected 100", bus.display);
    else n_pass++;
    n      = 0;
    kr_low = 1'b1;
    bus.key       = 4'd5;
    bus.key_valid = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.key_ready !== 1'b0) kr_low = 1'b0;
      @(negedge clock);
      n++;
    end
    bus.key_valid = 1'b0;
    n_checks++;
    if (n != 32) $display("FAIL div_busy_cycles: got %0d expected 32", n);
    else n_pass++;
    n_checks++;
    if (kr_low !== 1'b1) $display("FAIL div_key_ready_low: got %b expected 1", kr_low);
    else n_pass++;
    n_checks++;
    if (bus.display !== 32'd14) $display("FAIL div_result: got %0d expected 14", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.hist_count !== 5'd1) $display("FAIL div_hist_count: got %0d expected 1", bus.hist_count);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    do_reset();
    press(4'd9); press(KEY_DIV); press(4'd0); press(KEY_EQ);
    n_checks++;
    if (bus.error !== 1'b1) $display("FAIL divzero_error: got %b expected 1", bus.error);
    else n_pass++;
    n_checks++;
    if (bus.display !== 32'hFFFF_FFFF) $display("FAIL divzero_display: got %0h expected ffffffff", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL divzero_busy: got %b expected 0", bus.busy);
    else n_pass++;
    press(4'd5);
    n_checks++;
    if (bus.display !== 32'hFFFF_FFFF) $display("FAIL error_ignore_digit: got %0h expected ffffffff", bus.display);
    else n_pass++;
    press(KEY_EQ);
    n_checks++;
    if (bus.error !== 1'b0) $display("FAIL error_clear: got %b expected 0", bus.error);
    else n_pass++;
    n_checks++;
    if (bus.display !== 32'd0) $display("FAIL error_clear_display: got %0d expected 0", bus.display);
    else n_pass++;
  endtask

  task automatic test_reset_mid_divide();
    do_reset();
    press(4'd1); press(4'd0); press(4'd0); press(KEY_DIV); press(4'd7); press(KEY_EQ);
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy);
    else n_pass++;
    n_checks++;
    if (bus.display !== 32'd0) $display("FAIL abort_display: got %0d expected 0", bus.display);
    else n_pass++;
    n_checks++;
    if (bus.key_ready !== 1'b1) $display("FAIL abort_key_ready: got %b expected 1", bus.key_ready);
    else n_pass++;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0) $display("FAIL abort_stays_idle: got %b expected 0", bus.busy);
    else n_pass++;
  endtask
`else
  task automatic test_div_disabled();
    do_reset();
    press(4'd8); press(KEY_DIV); press(4'd2);
    n_checks++;
    if (bus.display !== 32'd82) $display("FAIL nodiv_f_ignored: got %0d expected 82", bus.display);
    else n_pass++;
    press(KEY_EQ);
    n_checks++;
    if (bus.hist_count !== 5'd1) $display("FAIL nodiv_push: got %0d expected 1", bus.hist_count);
    else n_pass++;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.error !== 1'b0 || bus.key_ready !== 1'b1)
      $display("FAIL nodiv_flags: got busy=%b error=%b key_ready=%b expected 0 0 1",
               bus.busy, bus.error, bus.key_ready);
    else n_pass++;
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    reset         = 1'b0;
    bus.key       = 4'd0;
    bus.key_valid = 1'b0;

    test_reset();
    test_add();
    test_sub_chain();
    test_mul_wrap();
    test_digits();
    test_recall();
    test_ring_wrap();
`ifdef CALC_DIV_EN
    test_divide();
    test_div_zero();
    test_reset_mid_divide();
`else
    test_div_disabled();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
